cdb_arbiter: RTL
================

# cdb_arbiter

Arbiter for the result-broadcast path into the reorder buffer. It gives three producers one registered broadcast bus: ALU results, load results, and store-address-ready notices. Each producer has its own small FIFO, and one entry is granted per cycle in round-robin order. The reorder buffer, reservation stations and load/store buffer see at most one broadcast per cycle. A misprediction `roll_back` flushes everything in flight.

## Interface
Parameters:
- `ENTRY_W`, 5: ROB entry index width (32-entry ROB).
- `DEPTH`, 2: per-producer FIFO depth, power of two, ≥1.

Ports (clock is `clk_in`; reset is `rst_in`, synchronous, active-high):
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous active-high reset.
- `rdy_in` input 1: global ready; low pauses the block.
- `roll_back` input 1: flush from the reorder buffer.
- `alu_valid` input 1: ALU result offered.
- `alu_ready` output 1: ALU FIFO can accept.
- `alu_entry` input ENTRY_W: ALU ROB tag.
- `alu_result` input 32: ALU result.
- `alu_pc_result` input 32: ALU branch target.
- `ld_valid` input 1: load result offered.
- `ld_ready` output 1: load FIFO can accept.
- `ld_entry` input ENTRY_W: load ROB tag.
- `ld_result` input 32: load data.
- `st_valid` input 1: store-addressed notice offered.
- `st_ready` output 1: store FIFO can accept.
- `st_entry` input ENTRY_W: store ROB tag.
- `cdb_valid` output 1: broadcast strobe.
- `cdb_src` output 2: 0 = ALU, 1 = load, 2 = store.
- `cdb_entry` output ENTRY_W: tag of the broadcast entry.
- `cdb_result` output 32: result of the broadcast entry.
- `cdb_pc_result` output 32: branch target of the broadcast entry.

## Operation
- Handshake:
  - `X_ready = rdy_in && (count_X < DEPTH) && !roll_back`.
  - An entry is pushed at a rising edge when `X_valid && X_ready`.
  - `X_ready` is computed from the registered count only. A full FIFO does not accept in the same cycle it pops.
- FIFO contents:
  - ALU FIFO stores {entry, result, pc_result}.
  - Load FIFO stores {entry, result}.
  - Store FIFO stores {entry}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Round-robin arbitration:
  - Pointer `rr_ptr` holds 0, 1 or 2.
  - Search order is `rr_ptr`, then `rr_ptr`+1 mod 3, then `rr_ptr`+2 mod 3. The first non-empty FIFO is granted.
  - After a grant, `rr_ptr` ← granted+1 mod 3. With no grant, `rr_ptr` is unchanged.
  - Arbitration looks only at FIFO contents, never at the current-cycle `X_valid`.
- Broadcast on a granted edge:
  - The head of the granted FIFO is popped.
  - `cdb_valid` ← 1, `cdb_src` ← granted source, `cdb_entry` ← head tag.
  - ALU: `cdb_result` and `cdb_pc_result` from the FIFO entry.
  - Load: `cdb_result` from the FIFO entry, `cdb_pc_result` ← 0.
  - Store: `cdb_result` ← 0, `cdb_pc_result` ← 0.
- No grant: `cdb_valid` ← 0; all other outputs hold their values.
- A push and a pop on the same FIFO in the same edge are both performed, and the count is unchanged.
- Priority order per edge: `rst_in` > `roll_back` > `!rdy_in` > normal operation.
- `rst_in` or `roll_back`, at the edge where it is sampled:
  - All FIFOs are emptied and `rr_ptr` ← 0.
  - `cdb_valid` ← 0, `cdb_src` ← 0, `cdb_entry` ← 0, `cdb_result` ← 0, `cdb_pc_result` ← 0.
  - Any offer presented at that edge is dropped.
  - These are the reset values of every registered output.
- `rdy_in` low:
  - No push, no pop, no pointer change.
  - All outputs hold, including `cdb_valid`. Consumers ignore the bus while `rdy_in` is low.
  - All ready outputs are low.

## Timing
- Latency: an offer accepted at edge E into an empty FIFO can be granted at edge E+1. `cdb_valid` is high in the cycle after E+1, and consumers latch it at edge E+2.
- Each broadcast is held for exactly one cycle unless `rdy_in` is low.
- Throughput: one broadcast per cycle in total.
- With all three FIFOs continuously non-empty, each source gets one slot in every three.
- Ready outputs are combinational from the registered counts, `rdy_in` and `roll_back`. There is no combinational path from any `X_valid` to any output.

## Configuration
- `CDB_LOAD_PRIORITY_EN` defined:
  - A non-empty load FIFO is always granted first.
  - The ALU and store FIFOs round-robin among themselves.
  - A load grant leaves `rr_ptr` unchanged.
- `CDB_LOAD_PRIORITY_EN` undefined: pure three-way round-robin as described under Operation.

## Test plan
- Reset and flush:
  - Hold `rst_in` for 2 cycles with all valids high.
  - Required: all outputs 0, ready outputs low during reset, high on the cycle after reset releases, no broadcast after release.
- Single ALU result:
  - Offer `alu_entry`=5, `alu_result`=0x1234, `alu_pc_result`=0x80 at edge E.
  - Required: cdb_valid=1, cdb_src=0, cdb_entry=5 in exactly the cycle after E+1 and low the cycle after that.
- Three-way round-robin:
  - Offer ALU tag 1, load tag 2 and store tag 3 at the same edge.
  - Required: broadcasts on three consecutive cycles in src order 0, 1, 2. The store broadcast has cdb_result=0.
  - With the macro defined, the order is 1, 0, 2.
- Full FIFO:
  - Push ALU tags 1, 2, 3 back-to-back while the load FIFO is kept non-empty.
  - Required: `alu_ready` goes low after 2 accepts with DEPTH=2. Tag 3 is accepted only once the count drops. Tag order 1, 2, 3 is preserved across pointer wrap.
- Roll-back mid-stream:
  - Fill all FIFOs, then assert `roll_back` for one cycle while offering load tag 9.
  - Required: cdb_valid=0 on the next cycle. No stale or tag-9 broadcast ever appears. The next ALU offer is broadcast as src 0.
- Pause:
  - Drop `rdy_in` for 3 cycles while cdb_valid=1 with tag 7 and other entries are queued.
  - Required: outputs frozen at tag 7 and ready outputs low for those 3 cycles. The next grant follows round-robin order once `rdy_in` returns.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Result-broadcast arbiter: three producer FIFOs share one registered broadcast bus, granted round-robin.
// Optional CDB_LOAD_PRIORITY_EN: load results always win; ALU and store round-robin among themselves.

module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_dat_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] cnt_q;

    // Explicit wrap keeps non-power-of-two style pointer arithmetic safe for DEPTH=1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_in) begin
        if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) tail_q <= ptr_inc(tail_q);
            if (pop_i)  head_q <= ptr_inc(head_q);
            if (push_i && !pop_i)
                cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_i) mem_q[tail_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = cnt_q;
endmodule

module cdb_arbiter #(
    parameter int ENTRY_W = 5,
    parameter int DEPTH   = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [ENTRY_W-1:0] alu_entry,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        alu_pc_result,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [ENTRY_W-1:0] ld_entry,
    input  logic [31:0]        ld_result,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [ENTRY_W-1:0] st_entry,
    output logic               cdb_valid,
    output logic [1:0]         cdb_src,
    output logic [ENTRY_W-1:0] cdb_entry,
    output logic [31:0]        cdb_result,
    output logic [31:0]        cdb_pc_result
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ALU_W = ENTRY_W + 64;
    localparam int LD_W  = ENTRY_W + 32;

    logic               flush;
    logic               run;
    logic [CNT_W-1:0]   alu_cnt, ld_cnt, st_cnt;
    logic [ALU_W-1:0]   alu_head;
    logic [LD_W-1:0]    ld_head;
    logic [ENTRY_W-1:0] st_head;
    logic               alu_push, ld_push, st_push;
    logic               alu_pop, ld_pop, st_pop;
    logic [2:0]         non_empty;
    logic [2:0]         cand;
    logic               grant_vld;
    logic [1:0]         grant_src;
    logic [ENTRY_W-1:0] grant_entry;
    logic [31:0]        grant_result;
    logic [31:0]        grant_pc;
    logic [1:0]         rr_q, rr_d;

    assign flush = rst_in || roll_back;
    assign run   = rdy_in && !flush;

    // Ready depends only on registered counts, so a full FIFO cannot accept while it pops.
    assign alu_ready = run && (alu_cnt < CNT_W'(DEPTH));
    assign ld_ready  = run && (ld_cnt  < CNT_W'(DEPTH));
    assign st_ready  = run && (st_cnt  < CNT_W'(DEPTH));

    assign alu_push = alu_valid && alu_ready;
    assign ld_push  = ld_valid  && ld_ready;
    assign st_push  = st_valid  && st_ready;

    assign alu_pop = run && grant_vld && (grant_src == 2'd0);
    assign ld_pop  = run && grant_vld && (grant_src == 2'd1);
    assign st_pop  = run && grant_vld && (grant_src == 2'd2);

    cdb_fifo #(.W(ALU_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_alu_fifo (
        .clk_in     (clk_in),
        .flush_i    (flush),
        .push_i     (alu_push),
        .push_dat_i ({alu_entry, alu_result, alu_pc_result}),
        .pop_i      (alu_pop),
        .head_dat_o (alu_head),
        .count_o    (alu_cnt)
    );

    cdb_fifo #(.W(LD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_ld_fifo (
        .clk_in     (clk_in),
        .flush_i    (flush),
        .push_i     (ld_push),
        .push_dat_i ({ld_entry, ld_result}),
        .pop_i      (ld_pop),
        .head_dat_o (ld_head),
        .count_o    (ld_cnt)
    );

    cdb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_st_fifo (
        .clk_in     (clk_in),
        .flush_i    (flush),
        .push_i     (st_push),
        .push_dat_i (st_entry),
        .pop_i      (st_pop),
        .head_dat_o (st_head),
        .count_o    (st_cnt)
    );

    assign non_empty = {st_cnt != '0, ld_cnt != '0, alu_cnt != '0};

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_src = 2'd0;
        cand      = non_empty;
`ifdef CDB_LOAD_PRIORITY_EN
        if (non_empty[1]) begin
            grant_vld = 1'b1;
            grant_src = 2'd1;
        end
        cand[1] = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            if (!grant_vld && cand[rr_idx(rr_q, 2'(k))]) begin
                grant_vld = 1'b1;
                grant_src = rr_idx(rr_q, 2'(k));
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
`ifdef CDB_LOAD_PRIORITY_EN
            if (grant_src != 2'd1)
                rr_d = (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
`else
            rr_d = (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
`endif
        end
    end

    always_comb begin
        grant_entry  = st_head;
        grant_result = 32'd0;
        grant_pc     = 32'd0;
        case (grant_src)
            2'd0: begin
                grant_entry  = alu_head[ALU_W-1 -: ENTRY_W];
                grant_result = alu_head[63:32];
                grant_pc     = alu_head[31:0];
            end
            2'd1: begin
                grant_entry  = ld_head[LD_W-1 -: ENTRY_W];
                grant_result = ld_head[31:0];
            end
            default: ;
        endcase
    end

    // Bus holds its payload when idle; only the strobe drops.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            rr_q          <= 2'd0;
            cdb_valid     <= 1'b0;
            cdb_src       <= 2'd0;
            cdb_entry     <= '0;
            cdb_result    <= 32'd0;
            cdb_pc_result <= 32'd0;
        end else if (rdy_in) begin
            rr_q      <= rr_d;
            cdb_valid <= grant_vld;
            if (grant_vld) begin
                cdb_src       <= grant_src;
                cdb_entry     <= grant_entry;
                cdb_result    <= grant_result;
                cdb_pc_result <= grant_pc;
            end
        end
    end
endmodule
